// File: rtl/vga_pkg.sv
// Shared VGA-side types and the iron palette used by the thermal upscaler
// and any future on-screen legend.
package vga_pkg;

  // Index 2 = R, 1 = G, 0 = B.
  typedef logic [2:0][7:0] rgb_t;

  function automatic rgb_t f_iron(input logic [7:0] v);
    rgb_t c;
    logic [7:0] dbl;
    // dbl is 2*v for v<128 and 2*(v-128) for v>=128, so one shift serves both halves.
    dbl = {v[6:0], 1'b0};
    c[2] = v[7] ? 8'hff : dbl;
    c[1] = v[7] ? dbl : 8'h00;
    if (!v[7]) begin
      c[0] = dbl;
    end else if (!v[6]) begin
      c[0] = 8'hff - {v[5:0], 2'b00};
    end else begin
      c[0] = 8'h00;
    end
    return c;
  endfunction

endpackage

// File: rtl/thermal_palette.sv
// Final output register: iron-palette colour inside the image window,
// flat border grey outside it, black during blanking.
module thermal_palette
  import vga_pkg::*;
#(
  parameter logic [7:0] p_border = 8'h10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       blank,
  input  logic       in_win,
  input  logic [7:0] index,
  output rgb_t       rgb
);

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb <= '0;
    end else if (blank) begin
      rgb <= '0;
    end else if (in_win) begin
      rgb <= f_iron(index);
    end else begin
      rgb <= {3{p_border}};
    end
  end

endmodule

// File: rtl/thermal_upscaler.sv
// Raster-tracking pixel source: fetches the low-res thermal frame, replicates
// each source pixel p_scale x p_scale, and re-emits timing 3 clk late.
module thermal_upscaler
  import vga_pkg::*;
#(
  parameter int         p_src_w  = 32,
  parameter int         p_src_h  = 24,
  parameter int         p_scale  = 16,
  parameter int         p_x_off  = 64,
  parameter int         p_y_off  = 48,
  parameter bit         p_vs_pol = 1'b1,
  parameter logic [7:0] p_border = 8'h10,
  localparam int        AW       = $clog2(p_src_w * p_src_h)
) (
  input  logic          i_clk_pixel,
  input  logic          i_rst,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic          i_blank,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  input  logic [7:0]    i_rd_data,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_blank,
  output rgb_t          o_data
);

  localparam int CW   = 12;
  localparam int COLW = $clog2(p_src_w + 1);
  localparam int ROWW = $clog2(p_src_h + 1);
  localparam int SW   = (p_scale > 1) ? $clog2(p_scale) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(p_scale - 1);

  logic [CW-1:0]   x;
  logic [CW-1:0]   y;
  logic            blank_prev;
  logic            vs_prev;
  logic            frame_ok;
  logic [COLW-1:0] col;
  logic [SW-1:0]   sub_col;
  logic [ROWW-1:0] row;
  logic [SW-1:0]   sub_row;
  logic [AW-1:0]   base;
  logic            win2;
  logic [2:0]      hs_d;
  logic [2:0]      vs_d;
  logic [2:0]      bl_d;

  logic vs_act;
  logic vs_edge;
  logic line_end;
  logic in_x;
  logic in_y;
  logic in_win;

  // S0: raster position and window decode from the live timing inputs.
  always_comb begin
    vs_act   = (i_vsync == p_vs_pol);
    vs_edge  = vs_act & ~vs_prev;
    line_end = i_blank & ~blank_prev;
    in_x     = (x >= CW'(p_x_off)) && (col < COLW'(p_src_w));
    in_y     = (y >= CW'(p_y_off)) && (row < ROWW'(p_src_h));
    in_win   = frame_ok & ~i_blank & in_x & in_y;
  end

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      x          <= '0;
      y          <= '0;
      blank_prev <= 1'b0;
      vs_prev    <= 1'b0;
      frame_ok   <= 1'b0;
      col        <= '0;
      sub_col    <= '0;
      row        <= '0;
      sub_row    <= '0;
      base       <= '0;
    end else begin
      blank_prev <= i_blank;
      vs_prev    <= vs_act;
      if (vs_edge) frame_ok <= 1'b1;

      if (i_blank) begin
        x       <= '0;
        col     <= '0;
        sub_col <= '0;
      end else begin
        x <= x + 1'b1;
        if (in_x) begin
          if (sub_col == SUB_LAST) begin
            sub_col <= '0;
            col     <= col + 1'b1;
          end else begin
            sub_col <= sub_col + 1'b1;
          end
        end
      end

      // Frame restart wins over a line end landing on the same clock.
      if (vs_edge) begin
        y       <= '0;
        row     <= '0;
        sub_row <= '0;
        base    <= '0;
      end else if (line_end) begin
        y <= y + 1'b1;
        if (in_y) begin
          if (sub_row == SUB_LAST) begin
            sub_row <= '0;
            row     <= row + 1'b1;
            base    <= base + AW'(p_src_w);
          end else begin
            sub_row <= sub_row + 1'b1;
          end
        end
      end
    end
  end

  // S1 read request, S2 window flag riding alongside the RAM's read latency.
  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      o_rd_en   <= 1'b0;
      o_rd_addr <= '0;
      win2      <= 1'b0;
      hs_d      <= '0;
      vs_d      <= '0;
      bl_d      <= '0;
    end else begin
      o_rd_en   <= in_win;
      o_rd_addr <= base + AW'(col);
      win2      <= o_rd_en;
      hs_d      <= {hs_d[1:0], i_hsync};
      vs_d      <= {vs_d[1:0], i_vsync};
      bl_d      <= {bl_d[1:0], i_blank};
    end
  end

  assign o_hsync = hs_d[2];
  assign o_vsync = vs_d[2];
  assign o_blank = bl_d[2];

  thermal_palette #(
    .p_border(p_border)
  ) u_palette (
    .clk   (i_clk_pixel),
    .rst   (i_rst),
    .blank (bl_d[1]),
    .in_win(win2),
    .index (i_rd_data),
    .rgb   (o_data)
  );

endmodule
